// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single-port data memory.
//   Port 0 (core load/store) and port 1 (auxiliary master) compete for one
//   memory port. One request is granted per cycle and steered onto o_mem_*.
//   Read data (1-cycle latency) is routed back to the issuing master.
//   Port 1 has bounded starvation (STARVE_LIMIT) and can lock the memory
//   for bursts via i_m1_lock.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_mX_req/addr/wdata/
//   i_mX_wstrb/we           per-master request (X = 0, 1)
//   i_m1_lock               port 1 keeps ownership after its grant
//   o_mX_gnt                combinational grant
//   o_mX_rvalid/rdata       read return, one cycle after a load grant
//   o_m0_stall              core request not granted this cycle
//   o_mem_*                 memory command, i_mem_rdata read data
// Configuration macro:
//   DMEM_ARB_RR_EN          round-robin conflict resolution (default: port 0 wins)
module dmem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_m0_req,
    input  logic [XLEN-1:0]            i_m0_addr,
    input  logic [XLEN-1:0]            i_m0_wdata,
    input  logic [XLEN/BYTE_WIDTH-1:0] i_m0_wstrb,
    input  logic                       i_m0_we,
    input  logic                       i_m1_req,
    input  logic [XLEN-1:0]            i_m1_addr,
    input  logic [XLEN-1:0]            i_m1_wdata,
    input  logic [XLEN/BYTE_WIDTH-1:0] i_m1_wstrb,
    input  logic                       i_m1_we,
    input  logic                       i_m1_lock,
    output logic                       o_m0_gnt,
    output logic                       o_m0_rvalid,
    output logic [XLEN-1:0]            o_m0_rdata,
    output logic                       o_m0_stall,
    output logic                       o_m1_gnt,
    output logic                       o_m1_rvalid,
    output logic [XLEN-1:0]            o_m1_rdata,
    output logic                       o_mem_en,
    output logic                       o_mem_we,
    output logic [XLEN-1:0]            o_mem_addr,
    output logic [XLEN-1:0]            o_mem_wdata,
    output logic [XLEN/BYTE_WIDTH-1:0] o_mem_wstrb,
    input  logic [XLEN-1:0]            i_mem_rdata
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic             rd_owner_q, rd_owner_d;
    logic             gnt0_c, gnt1_c;
    logic             starved_c;

`ifdef DMEM_ARB_RR_EN
    // 1 = port 1 was granted most recently; reset value lets port 0 win first
    logic             rr_last1_q, rr_last1_d;
`endif

    assign starved_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lock entry on a locked port 1 grant, exit when lock drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (gnt1_c && i_m1_lock) state_d = ARB_LOCKED;
            ARB_LOCKED: if (!i_m1_lock)          state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Grant outputs, gated by reset
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!i_rst) begin
            if (state_q == ARB_LOCKED) begin
                gnt1_c = i_m1_req;
            end else if (starved_c && i_m1_req) begin
                gnt1_c = 1'b1;
            end else if (i_m0_req && i_m1_req) begin
`ifdef DMEM_ARB_RR_EN
                gnt0_c = rr_last1_q;
                gnt1_c = ~rr_last1_q;
`else
                gnt0_c = 1'b1;
`endif
            end else begin
                gnt0_c = i_m0_req;
                gnt1_c = i_m1_req;
            end
        end
    end

    // Memory steering and next values of the bookkeeping registers
    always_comb begin
        o_mem_en     = gnt0_c | gnt1_c;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wstrb  = '0;
        if (gnt0_c) begin
            o_mem_we    = i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
            o_mem_wstrb = i_m0_wstrb;
        end else if (gnt1_c) begin
            o_mem_we    = i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
            o_mem_wstrb = i_m1_wstrb;
        end

        starve_cnt_d = starve_cnt_q;
        if (!i_m1_req || gnt1_c) begin
            starve_cnt_d = '0;
        end else if (!starved_c) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        rd_pending_d = o_mem_en & ~o_mem_we;
        rd_owner_d   = gnt1_c;

`ifdef DMEM_ARB_RR_EN
        rr_last1_d = rr_last1_q;
        if (gnt1_c) begin
            rr_last1_d = 1'b1;
        end else if (gnt0_c) begin
            rr_last1_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_q <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_last1_q <= 1'b1;
        end else begin
            rr_last1_q <= rr_last1_d;
        end
    end
`endif

    assign o_m0_gnt    = gnt0_c;
    assign o_m1_gnt    = gnt1_c;
    assign o_m0_stall  = i_m0_req & ~gnt0_c & ~i_rst;
    // A load pending across a reset edge is dropped by the reset gating here
    assign o_m0_rvalid = rd_pending_q & ~rd_owner_q & ~i_rst;
    assign o_m1_rvalid = rd_pending_q &  rd_owner_q & ~i_rst;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter (XLEN=32, STARVE_LIMIT=8).
module tb_dmem_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = 4;
    localparam int          LIMIT  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_m0_req, i_m0_we, i_m1_req, i_m1_we, i_m1_lock;
    logic [XLEN-1:0]   i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_mem_rdata;
    logic [STRB_W-1:0] i_m0_wstrb, i_m1_wstrb;
    logic              o_m0_gnt, o_m0_rvalid, o_m0_stall, o_m1_gnt, o_m1_rvalid;
    logic [XLEN-1:0]   o_m0_rdata, o_m1_rdata, o_mem_addr, o_mem_wdata;
    logic              o_mem_en, o_mem_we;
    logic [STRB_W-1:0] o_mem_wstrb;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.XLEN(XLEN), .BYTE_WIDTH(8), .STARVE_LIMIT(LIMIT)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .i_m0_wstrb(i_m0_wstrb), .i_m0_we(i_m0_we),
        .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .i_m1_wstrb(i_m1_wstrb), .i_m1_we(i_m1_we), .i_m1_lock(i_m1_lock),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .o_m0_stall(o_m0_stall),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Owner of each expected read return, oldest first
    bit sb_q[$];

    // Reference state
    bit m_locked = 1'b0;
    int m_cnt    = 0;
    bit m_last1  = 1'b1;
    bit e0, e1;
    bit g1_seen;

    logic [XLEN-1:0]   wd0 = 32'h0000_0000, wd1 = 32'h0000_0000;
    logic [STRB_W-1:0] ws0 = 4'h0, ws1 = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model
    task automatic cycle(input bit r0, input logic [31:0] a0, input bit w0,
                         input bit r1, input logic [31:0] a1, input bit w1,
                         input bit lk, input logic [31:0] md);
        bit rv0, rv1, own;
        logic [31:0] ea, ewd;
        logic [3:0]  es;
        bit          ewe;
        i_m0_req = r0; i_m0_addr = a0; i_m0_we = w0; i_m0_wdata = wd0; i_m0_wstrb = ws0;
        i_m1_req = r1; i_m1_addr = a1; i_m1_we = w1; i_m1_wdata = wd1; i_m1_wstrb = ws1;
        i_m1_lock = lk; i_mem_rdata = md;
        #4;
        e0 = 1'b0; e1 = 1'b0;
        if (i_rst) begin
        end else if (m_locked) begin
            e1 = r1;
        end else if (m_cnt == LIMIT && r1) begin
            e1 = 1'b1;
        end else if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            e0 = m_last1; e1 = !m_last1;
`else
            e0 = 1'b1;
`endif
        end else begin
            e0 = r0; e1 = r1;
        end
        ea = 32'h0; ewd = 32'h0; es = 4'h0; ewe = 1'b0;
        if (e0) begin ea = a0; ewd = wd0; es = ws0; ewe = w0; end
        if (e1) begin ea = a1; ewd = wd1; es = ws1; ewe = w1; end
        g1_seen = o_m1_gnt;
        check("gnt0", 32'(o_m0_gnt), 32'(e0));
        check("gnt1", 32'(o_m1_gnt), 32'(e1));
        check("stall", 32'(o_m0_stall), 32'(r0 && !e0 && !i_rst));
        check("mem_en", 32'(o_mem_en), 32'(e0 || e1));
        check("mem_we", 32'(o_mem_we), 32'(ewe));
        check("mem_addr", o_mem_addr, ea);
        check("mem_wdata", o_mem_wdata, ewd);
        check("mem_wstrb", 32'(o_mem_wstrb), 32'(es));
        rv0 = 1'b0; rv1 = 1'b0;
        if (sb_q.size() > 0) begin
            own = sb_q.pop_front();
            if (!i_rst) begin
                if (own) rv1 = 1'b1; else rv0 = 1'b1;
            end
        end
        check("rvalid0", 32'(o_m0_rvalid), 32'(rv0));
        check("rvalid1", 32'(o_m1_rvalid), 32'(rv1));
        check("rdata0", o_m0_rdata, rv0 ? md : 32'h0);
        check("rdata1", o_m1_rdata, rv1 ? md : 32'h0);
        if ((e0 && !w0) || (e1 && !w1)) sb_q.push_back(e1);
        @(posedge i_clk);
        if (i_rst) begin
            m_locked = 1'b0; m_cnt = 0; m_last1 = 1'b1;
            sb_q.delete();
        end else begin
            if (!r1 || e1) m_cnt = 0;
            else if (m_cnt < LIMIT) m_cnt++;
            if (m_locked && !lk) m_locked = 1'b0;
            else if (!m_locked && e1 && lk) m_locked = 1'b1;
            if (e1) m_last1 = 1'b1;
            else if (e0) m_last1 = 1'b0;
        end
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        // Reset with both masters requesting: every output must stay 0
        cycle(1'b1, 32'h4, 1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h1234_5678);
        cycle(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h1234_5678);
        i_rst = 1'b0;

        // Solo port 0 load, memory returns 0xDEADBEEF next cycle
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("solo_rdata", o_m0_rdata, 32'h0);  // data only for the return cycle

        // Continuous conflict from reset
        i_rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        i_rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 32'h20 + 32'(i), 1'b0, 1'b1, 32'h80 + 32'(i), 1'b0, 1'b0, $urandom);
`ifdef DMEM_ARB_RR_EN
            check("rr_pattern", 32'(g1_seen), 32'(i % 2 == 1));
`else
            check("starve_pattern", 32'(g1_seen), 32'(i % 9 == 8));
`endif
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);

        // Locked port 1 store burst while port 0 waits
        wd1 = 32'hA5A5_A5A5; ws1 = 4'hF; wd0 = 32'h1111_2222; ws0 = 4'h3;
        cycle(1'b0, 32'h44, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h44, 1'b1, 1'b1, 32'h40 + 32'(4*i), 1'b1, 1'b1, $urandom);
        cycle(1'b1, 32'h44, 1'b1, 1'b1, 32'h50, 1'b1, 1'b0, $urandom);
        cycle(1'b1, 32'h44, 1'b1, 1'b1, 32'h54, 1'b1, 1'b0, $urandom);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);

        // Pipelined loads 0,1,0 with no bubbles
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'hAAAA_0001);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'hBBBB_0002);
        cycle(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'hCCCC_0003);

        // Reset with a port 1 load pending
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        i_rst = 1'b1;
        cycle(1'b1, 32'h8, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h5555_6666);
        i_rst = 1'b0;
        cycle(1'b1, 32'h8, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h7777_8888);
        check("post_reset_winner", 32'(g1_seen), 32'h0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            wd0 = $urandom; wd1 = $urandom;
            ws0 = 4'($urandom); ws1 = 4'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                  1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                  1'($urandom_range(0, 4) == 0), $urandom);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single-port data memory. Port 0 is the core load-store path: address, write data, strobe and write-enable already translated to a DMEM-relative offset. Port 1 is an auxiliary master such as a debug or loader engine. The arbiter grants one request per cycle, steers it onto the memory port, and routes the one-cycle-latency read data back to the issuing master. It also provides a core stall, bounded auxiliary starvation and an auxiliary lock for bursts.

## Interface
- `STARVE_LIMIT`, default 8: consecutive cycles port 1 may request without a grant before it is forced to win. Legal range 1..255.
- `i_clk` input, 1 bit: clock.
- `i_rst` input, 1 bit: synchronous reset, active-high.
- `i_mX_req` input, 1 bit (X = 0, 1): access request, level.
- `i_mX_addr` input, XLEN bits: DMEM byte offset.
- `i_mX_wdata` input, XLEN bits: write data.
- `i_mX_wstrb` input, XLEN/BYTE_WIDTH bits: byte strobes.
- `i_mX_we` input, 1 bit: 1 = store, 0 = load.
- `i_m1_lock` input, 1 bit: keep port 1 ownership after its current grant.
- `o_mX_gnt` output, 1 bit: request accepted this cycle.
- `o_mX_rvalid` output, 1 bit: read data valid for port X.
- `o_mX_rdata` output, XLEN bits: read data for port X.
- `o_m0_stall` output, 1 bit: equals `i_m0_req & ~o_m0_gnt`.
- `o_mem_en` output, 1 bit: memory access this cycle.
- `o_mem_we` output, 1 bit: memory write enable.
- `o_mem_addr` output, XLEN bits: memory address.
- `o_mem_wdata` output, XLEN bits: memory write data.
- `o_mem_wstrb` output, XLEN/BYTE_WIDTH bits: memory byte strobes.
- `i_mem_rdata` input, XLEN bits: memory read data, valid one cycle after a read with `o_mem_en=1`.

## Operation
- **States:**
  - ARB_IDLE: normal arbitration.
  - ARB_LOCKED: port 1 owns the memory exclusively.
- **ARB_IDLE grant rules**, in priority order:
  1. Starvation counter `starve_cnt == STARVE_LIMIT` and `i_m1_req`: grant port 1.
  2. Only one port requests: grant that port.
  3. Both ports request: winner chosen by the policy in Configuration.
- **Grant outputs:**
  - At most one of `o_m0_gnt` / `o_m1_gnt` is high in any cycle.
  - Grants are combinational from the requests, state and `starve_cnt`.
- **Memory steering:**
  - `o_mem_*` copy the granted port's addr, wdata, wstrb and we.
  - `o_mem_en = o_m0_gnt | o_m1_gnt`.
  - With no grant, all `o_mem_*` are 0.
- **Starvation counter:**
  - Increments, saturating at STARVE_LIMIT, in every cycle where `i_m1_req & ~o_m1_gnt`.
  - Clears to 0 on any port 1 grant, or when `i_m1_req` is low.
- **Lock:**
  - A port 1 grant with `i_m1_lock=1` moves ARB_IDLE to ARB_LOCKED.
  - In ARB_LOCKED, port 0 is never granted and port 1 is granted whenever `i_m1_req=1`.
  - Return to ARB_IDLE in the first cycle `i_m1_lock=0` is sampled; that cycle still arbitrates as locked.
- **Read return:**
  - A registered `rd_pending` bit and `rd_owner` bit capture each granted load.
  - Next cycle, `o_m<rd_owner>_rvalid=1` and that port's `o_mX_rdata = i_mem_rdata`.
  - The other port's rdata is 0.
  - Stores never produce rvalid.
- **Back-to-back:** a new grant is allowed in the same cycle as a read return; there are no bubbles.

## Timing
- Grant and memory command: 0 cycles (combinational) from request.
- Load data: exactly 1 cycle after grant.
- Store takes effect at the clock edge ending the grant cycle.
- Reset values:
  - State ARB_IDLE; `starve_cnt=0`; `rd_pending=0`; `rd_owner=0`.
  - Round-robin pointer = "port 1 last", so port 0 wins the first conflict.
- Reset outputs: all `o_*` are 0 while `i_rst=1`, since grants are gated by reset.
- Reset during a pending read: the rvalid is dropped and never emitted.
- A master may change or drop its request in any cycle. Ungranted requests are not remembered; masters must hold req until `gnt`.

## Configuration
- `DMEM_ARB_RR_EN` defined: on conflict in ARB_IDLE, the port not granted most recently wins. The pointer updates on every grant.
- `DMEM_ARB_RR_EN` undefined: port 0 always wins conflicts, and the pointer logic is removed. The starvation rule is the only path for port 1 under continuous port 0 traffic.

## Test plan
- **Solo traffic:** port 0 load at `0x10` with memory returning `0xDEADBEEF` -> `o_m0_gnt=1` same cycle; `o_m0_rvalid=1` and `o_m0_rdata=0xDEADBEEF` next cycle; `o_m1_rvalid=0`.
- **Continuous conflict, macro undefined, STARVE_LIMIT=8:** both ports request continuously -> port 0 granted 8 cycles, port 1 granted on the 9th, then the pattern repeats; `o_m0_stall=1` only on port 1 cycles.
- **Continuous conflict, macro defined:** both ports request continuously -> grants alternate 0,1,0,1 starting with 0 after reset.
- **Lock:** port 1 store word `0xA5A5A5A5` with strobe `4'b1111` and `i_m1_lock=1` for 4 cycles while port 0 requests -> port 0 gets no grant until the cycle after lock drops; `o_m0_stall=1` throughout.
- **Pipelined reads:** back-to-back loads port 0, port 1, port 0 -> `rvalid` rises on the matching port each following cycle with the correct data and no bubbles.
- **Reset with read pending:** `i_rst` asserted the cycle after a port 1 load grant -> no `o_m1_rvalid`; all outputs 0; first post-reset conflict granted to port 0.
